rlbp_seq_ctrl: RTL and testbench

//  Hardware sequencer for the RLBP core; replaces per-bit firmware pokes of its control register.
//  - Takes a 3x3 pixel job from the host (Wishbone-side register file).
//  - Loads the job row by row: ce_d1..3 and d.
//  - Pulses start, then waits for rlbp_done with a timeout.
//  - Deserialises the serial result and hands it back on a valid/ready port.

---
 rtl/rlbp_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rlbp_seq_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rlbp_seq_ctrl.sv
// Job sequencer for the RLBP core: loads a 3x3 pixel job row by row, pulses start,
// waits for done with a timeout, deserialises the result and returns it on a valid/ready port.
module rlbp_seq_ctrl #(
  parameter int PIX_W   = 4,
  parameter int RES_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               soft_clr_i,
  input  logic               job_valid_i,
  output logic               job_ready_o,
  input  logic [9*PIX_W-1:0] job_pix_i,
  input  logic [1:0]         job_sel_i,
  output logic [2:0]         rlbp_ce_o,
  output logic [PIX_W-1:0]   rlbp_d_o,
  output logic [1:0]         rlbp_data_sel_o,
  output logic               rlbp_start_o,
  output logic               rlbp_reset_fsm_o,
  input  logic               rlbp_done_i,
  input  logic               rlbp_ser_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [RES_W-1:0]   res_data_o,
  output logic               res_err_o,
  output logic               busy_o,
  output logic [15:0]        jobs_done_o
);

  localparam int WCNT_W   = $clog2(TIMEOUT + 1);
  localparam int STEP_MAX = (RES_W > 9) ? RES_W : 9;
  localparam int STEP_W   = $clog2(STEP_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_SHIFT,
    S_ERR,
    S_OUT
  } state_e;

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [WCNT_W-1:0]    wait_q, wait_d;
  logic [9*PIX_W-1:0]   pix_q, pix_d;
  logic                 job_ready_q, job_ready_d;
  logic [2:0]           ce_q, ce_d;
  logic [PIX_W-1:0]     pixd_q, pixd_d;
  logic [1:0]           data_sel_q, data_sel_d;
  logic                 start_q, start_d;
  logic                 reset_fsm_q, reset_fsm_d;
  logic                 res_valid_q, res_valid_d;
  logic [RES_W-1:0]     res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic                 busy_q, busy_d;
  logic [15:0]          jobs_done_q, jobs_done_d;

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      wait_q      <= '0;
      pix_q       <= '0;
      job_ready_q <= 1'b0;
      ce_q        <= '0;
      pixd_q      <= '0;
      data_sel_q  <= '0;
      start_q     <= 1'b0;
      reset_fsm_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      pix_q       <= pix_d;
      job_ready_q <= job_ready_d;
      ce_q        <= ce_d;
      pixd_q      <= pixd_d;
      data_sel_q  <= data_sel_d;
      start_q     <= start_d;
      reset_fsm_q <= reset_fsm_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    pix_d       = pix_q;
    job_ready_d = job_ready_q;
    ce_d        = ce_q;
    pixd_d      = pixd_q;
    data_sel_d  = data_sel_q;
    start_d     = 1'b0;
    reset_fsm_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    jobs_done_d = jobs_done_q;

    if (soft_clr_i) begin
      state_d     = S_IDLE;
      job_ready_d = 1'b0;
      ce_d        = '0;
      res_valid_d = 1'b0;
      res_data_d  = '0;
      res_err_d   = 1'b0;
      reset_fsm_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          job_ready_d = 1'b1;
          if (job_valid_i && job_ready_q) begin
            pix_d       = job_pix_i;
            data_sel_d  = job_sel_i;
            job_ready_d = 1'b0;
            step_d      = '0;
            res_data_d  = '0;
            res_err_d   = 1'b0;
            state_d     = S_LOAD;
          end
        end
        S_LOAD: begin
          // Pixel k belongs to row k/3; each row has its own clock enable.
          if (step_q < STEP_W'(3))      ce_d = 3'b001;
          else if (step_q < STEP_W'(6)) ce_d = 3'b010;
          else                          ce_d = 3'b100;
          pixd_d = pix_q[PIX_W*int'(step_q) +: PIX_W];
          step_d = step_q + STEP_W'(1);
          if (step_q == STEP_W'(8)) state_d = S_START;
        end
        S_START: begin
          start_d = 1'b1;
          ce_d    = '0;
          wait_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (rlbp_done_i) begin
            step_d  = '0;
            state_d = S_SHIFT;
          end else if (wait_q == WCNT_W'(TIMEOUT)) begin
            reset_fsm_d = 1'b1;
            res_err_d   = 1'b1;
            res_data_d  = '0;
            state_d     = S_ERR;
          end else begin
            wait_d = wait_q + WCNT_W'(1);
          end
        end
        S_SHIFT: begin
          res_data_d = {res_data_q[RES_W-2:0], rlbp_ser_i};
          step_d     = step_q + STEP_W'(1);
          if (step_q == STEP_W'(RES_W - 1)) begin
            res_valid_d = 1'b1;
            state_d     = S_OUT;
          end
        end
        S_ERR: begin
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end
        S_OUT: begin
          if (res_ready_i) begin
            res_valid_d = 1'b0;
            jobs_done_d = jobs_done_q + 16'd1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign job_ready_o      = job_ready_q;
  assign rlbp_ce_o        = ce_q;
  assign rlbp_d_o         = pixd_q;
  assign rlbp_data_sel_o  = data_sel_q;
  assign rlbp_start_o     = start_q;
  assign rlbp_reset_fsm_o = reset_fsm_q;
  assign res_valid_o      = res_valid_q;
  assign res_data_o       = res_data_q;
  assign res_err_o        = res_err_q;
  assign busy_o           = busy_q;
  assign jobs_done_o      = jobs_done_q;

endmodule

// File: tb/tb_rlbp_seq_ctrl.sv
// Directed bench for rlbp_seq_ctrl: load sequencing, result capture, timeout, hold-off,
// soft clear and asynchronous reset, each with hand-computed expectations.
module tb_rlbp_seq_ctrl;

  localparam int PIX_W   = 4;
  localparam int RES_W   = 8;
  localparam int TIMEOUT = 1023;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               soft_clr = 1'b0;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [9*PIX_W-1:0] job_pix = '0;
  logic [1:0]         job_sel = '0;
  logic [2:0]         ce;
  logic [PIX_W-1:0]   d;
  logic [1:0]         data_sel;
  logic               start;
  logic               reset_fsm;
  logic               done = 1'b0;
  logic               ser = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [RES_W-1:0]   res_data;
  logic               res_err;
  logic               busy;
  logic [15:0]        jobs_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  int exp_jobs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rlbp_seq_ctrl #(.PIX_W(PIX_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .soft_clr_i      (soft_clr),
    .job_valid_i     (job_valid),
    .job_ready_o     (job_ready),
    .job_pix_i       (job_pix),
    .job_sel_i       (job_sel),
    .rlbp_ce_o       (ce),
    .rlbp_d_o        (d),
    .rlbp_data_sel_o (data_sel),
    .rlbp_start_o    (start),
    .rlbp_reset_fsm_o(reset_fsm),
    .rlbp_done_i     (done),
    .rlbp_ser_i      (ser),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .res_data_o      (res_data),
    .res_err_o       (res_err),
    .busy_o          (busy),
    .jobs_done_o     (jobs_done)
  );

  function automatic logic [38:0] all_outs();
    return {job_ready, ce, d, data_sel, start, reset_fsm, res_valid, res_data, res_err, busy, jobs_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a job once job_ready is seen and records the accept edge in t_acc.
  task automatic offer_job(input logic [9*PIX_W-1:0] pix, input logic [1:0] sel);
    int n = 0;
    while (!job_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready: job_ready=%b after %0d cycles, want 1", job_ready, n);
    end
    job_pix   = pix;
    job_sel   = sel;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    t_acc     = cyc;
    checks++;
    if ({job_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL accept: ready/busy=%b%b want 01", job_ready, busy);
    end
  endtask

  // Walks edges T+1..T+10, checking ce/d/sel per pixel and the start pulse.
  task automatic check_load(input logic [9*PIX_W-1:0] pix, input logic [1:0] sel, input bit stale_done);
    logic [2:0]       exp_ce;
    logic [PIX_W-1:0] exp_d;
    if (stale_done) done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_ce = 3'(1 << (k / 3));
      exp_d  = pix[k*PIX_W +: PIX_W];
      checks++;
      if ({ce, d, data_sel, start} !== {exp_ce, exp_d, sel, 1'b0}) begin
        errors++;
        $display("FAIL load[%0d]: ce=%b d=%h sel=%0d start=%b want ce=%b d=%h sel=%0d start=0",
                 k, ce, d, data_sel, start, exp_ce, exp_d, sel);
      end
    end
    tick();
    done = 1'b0;
    exp_d = pix[8*PIX_W +: PIX_W];
    checks++;
    if ({ce, d, data_sel, start, cyc - t_acc} !== {3'b000, exp_d, sel, 1'b1, 10}) begin
      errors++;
      $display("FAIL start_pulse: ce=%b d=%h sel=%0d start=%b at T+%0d want ce=0 d=%h sel=%0d start=1 at T+10",
               ce, d, data_sel, start, cyc - t_acc, exp_d, sel);
    end
  endtask

  // Holds done low for n WAIT edges, then pulses it once.
  task automatic give_done(input int n);
    for (int i = 0; i < n; i++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL start_drop: start=%b want 0", start);
    end
  endtask

  task automatic feed_bits(input logic [RES_W-1:0] bits);
    for (int i = 0; i < RES_W; i++) begin
      ser = bits[RES_W-1-i];
      if (i == RES_W - 1) begin
        checks++;
        if (res_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: res_valid=%b one edge before the last bit, want 0", res_valid);
        end
      end
      tick();
    end
    ser = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [RES_W-1:0] exp_data,
                              input logic exp_err, input int exp_lat);
    checks++;
    if ({res_valid, res_data, res_err} !== {1'b1, exp_data, exp_err} || (cyc - t_acc) != exp_lat) begin
      errors++;
      $display("FAIL %s: valid=%b data=%h err=%b at T+%0d want valid=1 data=%h err=%b at T+%0d",
               name, res_valid, res_data, res_err, cyc - t_acc, exp_data, exp_err, exp_lat);
    end
  endtask

  task automatic handshake(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_jobs++;
    checks++;
    if ({res_valid, job_ready, jobs_done} !== {1'b0, 1'b0, 16'(exp_jobs)}) begin
      errors++;
      $display("FAIL %s_hs: valid=%b ready=%b jobs=%0d want valid=0 ready=0 jobs=%0d",
               name, res_valid, job_ready, jobs_done, exp_jobs);
    end
    tick();
    checks++;
    if ({job_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL %s_idle: ready/busy=%b%b want 10", name, job_ready, busy);
    end
  endtask

  task automatic test_reset();
    job_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outs: outputs=%h want 0", all_outs());
    end
    job_valid = 1'b0;
    rst_n     = 1'b1;
    checks++;
    if (job_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: job_ready=%b before first edge, want 0", job_ready);
    end
    tick();
    checks++;
    if ({job_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready: ready/busy=%b%b after first edge, want 10", job_ready, busy);
    end
  endtask

  // Spurious done during LOAD must not shorten WAIT.
  task automatic test_load_and_result();
    offer_job(36'h987654321, 2'd2);
    check_load(36'h987654321, 2'd2, 1'b1);
    give_done(5);
    feed_bits(8'hB2);
    check_result("result_b2", 8'hB2, 1'b0, 24);
    checks++;
    if (jobs_done !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL jobs_pre_hs: jobs=%0d want %0d", jobs_done, exp_jobs);
    end
    handshake("job1");
  endtask

  // Result waits under back-pressure; the next job is taken only once the port drains.
  task automatic test_back_to_back();
    bit hold_ok = 1'b1;
    offer_job(36'h123456789, 2'd1);
    check_load(36'h123456789, 2'd1, 1'b0);
    give_done(0);
    feed_bits(8'h3C);
    check_result("result_3c", 8'h3C, 1'b0, 19);
    job_pix   = 36'hFEDCBA0F1;
    job_sel   = 2'd3;
    job_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({res_valid, res_data, res_err, job_ready, busy} !== {1'b1, 8'h3C, 1'b0, 1'b0, 1'b1}) begin
        hold_ok = 1'b0;
        $display("FAIL hold[%0d]: valid=%b data=%h err=%b ready=%b busy=%b want 1 3c 0 0 1",
                 i, res_valid, res_data, res_err, job_ready, busy);
      end
    end
    checks++;
    if (!hold_ok) errors++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_jobs++;
    checks++;
    if ({res_valid, job_ready, jobs_done} !== {1'b0, 1'b0, 16'(exp_jobs)}) begin
      errors++;
      $display("FAIL b2b_hs: valid=%b ready=%b jobs=%0d want 0 0 %0d", res_valid, job_ready, jobs_done, exp_jobs);
    end
    tick();
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: job_ready=%b want 1", job_ready);
    end
    tick();
    job_valid = 1'b0;
    t_acc     = cyc;
    checks++;
    if ({job_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept: ready/busy=%b%b want 01", job_ready, busy);
    end
  endtask

  // Continues the job accepted above and never answers it.
  task automatic test_timeout();
    int n = 0;
    check_load(36'hFEDCBA0F1, 2'd3, 1'b0);
    while (reset_fsm !== 1'b1 && n < TIMEOUT + 50) begin
      tick();
      n++;
    end
    checks++;
    if ({reset_fsm, res_err, res_data, res_valid} !== {1'b1, 1'b1, 8'h00, 1'b0} || (cyc - t_acc) != 11 + TIMEOUT) begin
      errors++;
      $display("FAIL timeout_err: reset_fsm=%b err=%b data=%h valid=%b at T+%0d want 1 1 00 0 at T+%0d",
               reset_fsm, res_err, res_data, res_valid, cyc - t_acc, 11 + TIMEOUT);
    end
    tick();
    checks++;
    if (reset_fsm !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: reset_fsm=%b one cycle later, want 0", reset_fsm);
    end
    check_result("timeout_out", 8'h00, 1'b1, 12 + TIMEOUT);
    handshake("timeout");
  endtask

  task automatic test_done_at_timeout();
    bit quiet = 1'b1;
    offer_job(36'h000000000, 2'd0);
    check_load(36'h000000000, 2'd0, 1'b0);
    while (cyc < t_acc + 10 + TIMEOUT) begin
      tick();
      if (reset_fsm !== 1'b0) quiet = 1'b0;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    if (reset_fsm !== 1'b0) quiet = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL coincident_abort: reset_fsm pulsed although done met the timeout, want no pulse");
    end
    feed_bits(8'h5A);
    check_result("coincident", 8'h5A, 1'b0, 11 + TIMEOUT + RES_W);
    handshake("coincident");
  endtask

  task automatic test_soft_clr();
    bit idle_ok = 1'b1;
    offer_job(36'h111111111, 2'd1);
    check_load(36'h111111111, 2'd1, 1'b0);
    give_done(2);
    for (int i = 0; i < 3; i++) begin
      ser = 1'b1;
      tick();
    end
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    checks++;
    if ({busy, reset_fsm, res_valid, ce, start, res_err, res_data, jobs_done} !==
        {1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 16'(exp_jobs)}) begin
      errors++;
      $display("FAIL soft_clr: busy=%b rfsm=%b valid=%b ce=%b start=%b err=%b data=%h jobs=%0d want 0 1 0 000 0 0 00 %0d",
               busy, reset_fsm, res_valid, ce, start, res_err, res_data, jobs_done, exp_jobs);
    end
    tick();
    checks++;
    if ({reset_fsm, job_ready} !== 2'b01) begin
      errors++;
      $display("FAIL soft_clr_after: reset_fsm=%b ready=%b want 0 1", reset_fsm, job_ready);
    end
    for (int i = 0; i < 15; i++) begin
      done = i[0];
      ser  = ~i[1];
      tick();
      if ({res_valid, busy, jobs_done} !== {1'b0, 1'b0, 16'(exp_jobs)}) idle_ok = 1'b0;
    end
    done = 1'b0;
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL soft_clr_idle: valid=%b busy=%b jobs=%0d want 0 0 %0d", res_valid, busy, jobs_done, exp_jobs);
    end
  endtask

  task automatic test_async_reset();
    offer_job(36'hABCDEF123, 2'd2);
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h mid-cycle, want 0", all_outs());
    end
    exp_jobs = 0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({job_ready, busy, res_valid, jobs_done} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_recover: ready=%b busy=%b valid=%b jobs=%0d want 1 0 0 0",
               job_ready, busy, res_valid, jobs_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_and_result();
    test_back_to_back();
    test_timeout();
    test_done_at_timeout();
    test_soft_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
